// File: rtl/param_updown_counter.sv
// param_updown_counter: bounded up/down counter with wrap/saturate limits,
// sticky overflow/underflow flags and a one-cycle terminal-count pulse.
module param_updown_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Load,
  input  logic              UpDown,
  input  logic [WIDTH-1:0]  InData,
  input  logic [STEP_W-1:0] Step,
  input  logic [WIDTH-1:0]  MinLimit,
  input  logic [WIDTH-1:0]  MaxLimit,
  input  logic              Mode,
  input  logic              ClrFlags,
  output logic [WIDTH-1:0]  OutData,
  output logic              AtMax,
  output logic              AtMin,
  output logic              Ovf,
  output logic              Udf,
  output logic              TcPulse,
  output logic              CfgErr
);
  // one spare bit above the wider operand keeps sum and Min+Step from wrapping
  localparam int E = (STEP_W > WIDTH ? STEP_W : WIDTH) + 1;
  logic [E-1:0] cur, stp, sum;
  logic [WIDTH-1:0] clamp, nxt;
  logic in_rng, over, under, cnt, hit_o, hit_u, clr;
  assign CfgErr = MinLimit > MaxLimit;
  assign AtMax = OutData == MaxLimit;
  assign AtMin = OutData == MinLimit;
  always_comb begin
    cur = E'(OutData);
    stp = E'(Step);
    sum = cur + stp;
    in_rng = OutData >= MinLimit && OutData <= MaxLimit;
    over = sum > E'(MaxLimit);
    under = cur < E'(MinLimit) + stp;
    cnt = !CfgErr && !Load && Enable && in_rng;
    hit_o = cnt && UpDown && over;
    hit_u = cnt && !UpDown && under;
    clr = ClrFlags && !CfgErr;
    clamp = InData < MinLimit ? MinLimit : InData > MaxLimit ? MaxLimit : InData;
    nxt = CfgErr ? OutData :
          Load ? clamp :
          !Enable ? OutData :
          !in_rng ? MinLimit :
          UpDown ? (over ? (Mode ? MaxLimit : MinLimit) : WIDTH'(sum)) :
                   (under ? (Mode ? MinLimit : MaxLimit) : WIDTH'(cur - stp));
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      OutData <= '0;
      Ovf <= 1'b0;
      Udf <= 1'b0;
      TcPulse <= 1'b0;
    end else begin
      OutData <= nxt;
      Ovf <= hit_o || (Ovf && !clr);
      Udf <= hit_u || (Udf && !clr);
      TcPulse <= hit_o || hit_u;
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: scoreboard bench; directed vectors on an 8-bit counter,
// then a random regression of 4/8/16-bit counters against a behavioural model.
module tb_param_updown_counter;
  typedef struct {
    string nm;
    logic [2:0] m;
    logic [2:0][15:0] o;
    logic [2:0][2:0] f;
  } ent_t;
  typedef struct {
    int o;
    bit ov, ud, tc;
  } st_t;

  logic Clk = 0, Reset;
  logic en, ld, up, md, clr;
  logic [3:0] stp;
  logic [3:0] in4, mn4, mx4, o4;
  logic [7:0] in8, mn8, mx8, o8;
  logic [15:0] in16, mn16, mx16, o16;
  logic amx4, amn4, ov4, ud4, tc4, ce4;
  logic amx8, amn8, ov8, ud8, tc8, ce8;
  logic amx16, amn16, ov16, ud16, tc16, ce16;
  ent_t sb[$];
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  param_updown_counter #(.WIDTH(4), .STEP_W(4)) u4 (
    .Clk(Clk), .Reset(Reset), .Enable(en), .Load(ld), .UpDown(up), .InData(in4), .Step(stp),
    .MinLimit(mn4), .MaxLimit(mx4), .Mode(md), .ClrFlags(clr), .OutData(o4), .AtMax(amx4),
    .AtMin(amn4), .Ovf(ov4), .Udf(ud4), .TcPulse(tc4), .CfgErr(ce4));
  param_updown_counter #(.WIDTH(8), .STEP_W(4)) u8 (
    .Clk(Clk), .Reset(Reset), .Enable(en), .Load(ld), .UpDown(up), .InData(in8), .Step(stp),
    .MinLimit(mn8), .MaxLimit(mx8), .Mode(md), .ClrFlags(clr), .OutData(o8), .AtMax(amx8),
    .AtMin(amn8), .Ovf(ov8), .Udf(ud8), .TcPulse(tc8), .CfgErr(ce8));
  param_updown_counter #(.WIDTH(16), .STEP_W(4)) u16 (
    .Clk(Clk), .Reset(Reset), .Enable(en), .Load(ld), .UpDown(up), .InData(in16), .Step(stp),
    .MinLimit(mn16), .MaxLimit(mx16), .Mode(md), .ClrFlags(clr), .OutData(o16), .AtMax(amx16),
    .AtMin(amn16), .Ovf(ov16), .Udf(ud16), .TcPulse(tc16), .CfgErr(ce16));

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // expected {OutData, Ovf, Udf, TcPulse} per width after the next rising edge
  function automatic st_t mdl(st_t s, bit e_, bit l_, bit u_, bit m_, bit c_,
                              int ind, int st_, int lo, int hi);
    st_t n = s;
    bit ho = 0, hu = 0;
    int v;
    n.tc = 0;
    if (lo > hi) return n;
    if (l_) n.o = ind < lo ? lo : (ind > hi ? hi : ind);
    else if (e_) begin
      if (s.o < lo || s.o > hi) n.o = lo;
      else if (u_) begin
        v = s.o + st_;
        if (v > hi) begin ho = 1; n.o = m_ ? hi : lo; end else n.o = v;
      end else begin
        v = s.o - st_;
        if (v < lo) begin hu = 1; n.o = m_ ? lo : hi; end else n.o = v;
      end
    end
    n.ov = ho | (s.ov & !c_);
    n.ud = hu | (s.ud & !c_);
    n.tc = ho | hu;
    return n;
  endfunction

  // monitor: the counter presents a new result after every rising edge
  initial begin
    ent_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.m[0]) chk({e.nm, "/w4"}, {o4, ov4, ud4, tc4}, {e.o[0][3:0], e.f[0]});
        if (e.m[1]) chk({e.nm, "/w8"}, {o8, ov8, ud8, tc8}, {e.o[1][7:0], e.f[1]});
        if (e.m[2]) chk({e.nm, "/w16"}, {o16, ov16, ud16, tc16}, {e.o[2], e.f[2]});
      end
    end
  end

  task automatic s8(bit e_, bit l_, bit u_, bit m_, bit c_, int i_, int st_, int lo, int hi);
    en = e_; ld = l_; up = u_; md = m_; clr = c_;
    in8 = 8'(i_); stp = 4'(st_); mn8 = 8'(lo); mx8 = 8'(hi);
  endtask

  task automatic d(string nm, int o, bit ov, bit ud, bit tc);
    ent_t e;
    e.nm = nm; e.m = 3'b010; e.o = '0; e.f = '0;
    e.o[1] = 16'(o); e.f[1] = {ov, ud, tc};
    sb.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  initial begin
    st_t st[3];
    int mk[3] = '{15, 255, 65535};
    int mn[3], mx[3], ind[3];
    ent_t e;
    Reset = 0;
    s8(0, 0, 0, 0, 0, 0, 0, 0, 0);
    in4 = 0; mn4 = 0; mx4 = 0; in16 = 0; mn16 = 0; mx16 = 0;
    #1;
    chk("reset_state", {o8, ov8, ud8, tc8}, 0);
    @(negedge Clk) Reset = 1;
    // up wrap at the top of the full range
    s8(0, 1, 1, 0, 0, 254, 1, 0, 255); d("wrap_load", 254, 0, 0, 0);
    s8(1, 0, 1, 0, 0, 254, 1, 0, 255); d("wrap_c1", 255, 0, 0, 0);
    chk("wrap_atmax", amx8, 1);
    d("wrap_c2", 0, 1, 0, 1);
    chk("wrap_atmin", amn8, 1);
    d("wrap_c3", 1, 1, 0, 0);
    en = 0; d("wrap_hold", 1, 1, 0, 0);
    clr = 1; d("clr_flags", 1, 0, 0, 0);
    // down saturate
    s8(0, 1, 0, 1, 0, 14, 3, 10, 20); d("sat_load", 14, 0, 0, 0);
    en = 1; ld = 0;
    d("sat_c1", 11, 0, 0, 0);
    d("sat_c2", 10, 0, 1, 1);
    d("sat_c3", 10, 0, 1, 1);
    en = 0; d("sat_hold", 10, 0, 1, 0);
    // outside the window, then zero step
    s8(1, 0, 1, 0, 1, 0, 1, 30, 40); d("out_of_range", 30, 0, 0, 0);
    stp = 0; d("step_zero", 30, 0, 0, 0);
    // load clamp and clear/set collision
    s8(1, 1, 1, 0, 0, 50, 1, 0, 40); d("load_clamp", 40, 0, 0, 0);
    s8(0, 1, 1, 0, 0, 0, 1, 0, 40); d("load_zero", 0, 0, 0, 0);
    s8(1, 0, 0, 1, 0, 0, 1, 0, 40); d("udf_at_min", 0, 0, 1, 1);
    s8(0, 1, 0, 1, 0, 40, 1, 0, 40); d("load_keeps_flag", 40, 0, 1, 0);
    s8(1, 0, 1, 1, 1, 40, 1, 0, 40); d("clr_vs_set", 40, 1, 0, 1);
    s8(0, 0, 1, 1, 0, 40, 1, 0, 40); d("after_collide", 40, 1, 0, 0);
    // bad configuration freezes everything
    s8(1, 1, 1, 0, 1, 25, 1, 30, 20);
    #1 chk("cfgerr_set", ce8, 1);
    d("cfg_frozen1", 40, 1, 0, 0);
    ld = 0; d("cfg_frozen2", 40, 1, 0, 0);
    s8(1, 0, 1, 0, 0, 0, 1, 5, 50);
    #1 chk("cfgerr_clear", ce8, 0);
    d("cfg_resume", 41, 1, 0, 0);
    // asynchronous reset between edges
    s8(0, 1, 1, 0, 0, 100, 1, 0, 255); d("pre_reset", 100, 1, 0, 0);
    #1 Reset = 0; en = 1; ld = 0;
    #1 chk("async_reset", {o8, ov8, ud8, tc8}, 0);
    @(negedge Clk) Reset = 1;
    s8(1, 0, 1, 0, 0, 0, 1, 10, 255); d("first_after_reset", 10, 0, 0, 0);
    // random regression on all three widths
    #1 Reset = 0;
    @(negedge Clk) Reset = 1;
    for (int k = 0; k < 3; k++) st[k] = '{0, 0, 0, 0};
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 3) != 0;
      ld = $urandom_range(0, 9) == 0;
      up = 1'($urandom);
      md = 1'($urandom);
      clr = $urandom_range(0, 7) == 0;
      stp = 4'($urandom);
      for (int k = 0; k < 3; k++) begin
        mn[k] = $urandom_range(0, mk[k]);
        mx[k] = mn[k] + $urandom_range(0, 24);
        if (mx[k] > mk[k]) mx[k] = mk[k];
        if ($urandom_range(0, 15) == 0 && mn[k] > 0) mx[k] = mn[k] - 1;
        ind[k] = $urandom_range(0, mk[k]);
      end
      in4 = 4'(ind[0]); mn4 = 4'(mn[0]); mx4 = 4'(mx[0]);
      in8 = 8'(ind[1]); mn8 = 8'(mn[1]); mx8 = 8'(mx[1]);
      in16 = 16'(ind[2]); mn16 = 16'(mn[2]); mx16 = 16'(mx[2]);
      e.nm = $sformatf("rand%0d", i); e.m = 3'b111;
      for (int k = 0; k < 3; k++) begin
        st[k] = mdl(st[k], en, ld, up, md, clr, ind[k], int'(stp), mn[k], mx[k]);
        e.o[k] = 16'(st[k].o);
        e.f[k] = {st[k].ov, st[k].ud, st[k].tc};
      end
      sb.push_back(e);
      @(posedge Clk);
      #2;
    end
    en = 0; ld = 0;
    repeat (2) @(posedge Clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
